// File: rtl/uart_tx_core.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to build the parity bit; PARITY_ODD then selects odd (1) or even (0).
module uart_tx_core #(
    parameter int CLK_FREQ   = 48000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 serial_out,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'((DIV >= 2) ? DIV - 2 : 0);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_core: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_core: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_core: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic parity_bit;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   ready_en;

    // Reset clears ready_en asynchronously, so o_ready drops the moment reset rises.
    assign o_ready = (state == IDLE) && ready_en;

    // NOTE: every register here is assigned with <= so all of them see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_reg  <= '0;
            serial_out <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            ready_en   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            ready_en <= 1'b1;
            o_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        shift_reg  <= i_data;
`ifdef UART_TX_PARITY_EN
                        // Sampled on the same edge as shift_reg, so it reflects the latched word.
                        parity_bit <= (^i_data) ^ (PARITY_ODD != 0);
`endif
                        cnt        <= '0;
                        bit_idx    <= '0;
                        stop_idx   <= 1'b0;
                        serial_out <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        serial_out <= shift_reg[0];
                        state      <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            serial_out <= parity_bit;
                            state      <= PARITY;
`else
                            serial_out <= 1'b1;
                            state      <= STOP;
`endif
                        end else begin
                            bit_idx    <= bit_idx + 1'b1;
                            serial_out <= shift_reg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        serial_out <= 1'b1;
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Raise o_done one edge early so it is high during the final clock.
                        if (stop_idx == STOP_LAST && cnt == CNT_PRE) begin
                            o_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
